// File: rtl/debug_dump_tx_pkg.sv
// debug_dump_tx_pkg: shared FSM, phase and frame constants for the debug dump transmitter
package debug_dump_tx_pkg;
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_FETCH, S_LATCH, S_SEND, S_DONE} state_t;
    typedef enum logic [1:0] {PH_PC, PH_REG, PH_MEM} phase_t;
    localparam logic [7:0] FRAME_HEADER = 8'hA5;
endpackage

// File: rtl/debug_dump_tx_word_serializer.sv
// word_serializer: loads a 32-bit word and hands it out MSB-first as 4 valid/ready bytes
module word_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        last
);
    logic [31:0] shreg;
    logic [1:0]  cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            cnt      <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shreg    <= word;
            cnt      <= '0;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            shreg    <= {shreg[23:0], 8'h00};
            cnt      <= cnt + 2'd1;
            tx_valid <= cnt != 2'd3;
        end
    end
    assign tx_data = shreg[31:24];
    assign last    = tx_valid && tx_ready && cnt == 2'd3;
endmodule

// File: rtl/debug_dump_tx.sv
// debug_dump_tx: serialises PC, register file and data memory into a UART byte frame
module debug_dump_tx
    import debug_dump_tx_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          NREGS      = 32,
    parameter int          MEM_WORDS  = 32,
    parameter logic [7:0]  HEADER     = FRAME_HEADER
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_dump_start,
    input  logic [DATA_WIDTH-1:0]        i_pc,
    output logic [4:0]                   o_reg_addr,
    input  logic [DATA_WIDTH-1:0]        i_reg,
    output logic [$clog2(MEM_WORDS)-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0]        i_mem,
    output logic                         o_reg_send,
    output logic                         o_mem_send,
    output logic [7:0]                   o_tx_data,
    output logic                         o_tx_valid,
    input  logic                         i_tx_ready,
    output logic                         o_busy,
    output logic                         o_done
);
    localparam int MAW = $clog2(MEM_WORDS);
    state_t         state, state_next;
    phase_t         phase;
    logic [4:0]     reg_idx;
    logic [MAW-1:0] mem_idx;
    logic [7:0]     ser_data;
    logic           ser_valid, ser_last, word_end, last_word;
    assign word_end  = state == S_SEND && ser_last;
    assign last_word = phase == PH_MEM && mem_idx == MAW'(MEM_WORDS - 1);
    always_ff @(posedge i_clock) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_next;
    end
    // index counters saturate at the last word of each phase
    always_ff @(posedge i_clock) begin
        if (!i_reset || (state == S_IDLE && i_dump_start)) begin
            phase   <= PH_PC;
            reg_idx <= '0;
            mem_idx <= '0;
        end else if (word_end) begin
            if (phase == PH_PC) phase <= PH_REG;
            else if (phase == PH_REG) begin
                if (reg_idx == 5'(NREGS - 1)) phase <= PH_MEM;
                else                          reg_idx <= reg_idx + 5'd1;
            end else if (!last_word) mem_idx <= mem_idx + 1'b1;
        end
    end
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = i_dump_start ? S_HEADER : S_IDLE;
            S_HEADER: state_next = i_tx_ready ? S_FETCH : S_HEADER;
            S_FETCH:  state_next = S_LATCH;
            S_LATCH:  state_next = S_SEND;
            S_SEND:   state_next = !ser_last ? S_SEND : last_word ? S_DONE : S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end
    assign o_busy     = state != S_IDLE;
    assign o_done     = state == S_DONE;
    assign o_reg_send = state == S_FETCH && phase == PH_REG;
    assign o_mem_send = state == S_FETCH && phase == PH_MEM;
    assign o_reg_addr = reg_idx;
    assign o_mem_addr = mem_idx;
    assign o_tx_valid = state == S_HEADER || ser_valid;
    assign o_tx_data  = state == S_HEADER ? HEADER : ser_data;
    word_serializer u_ser (
        .clk      (i_clock),
        .rst      (!i_reset),
        .load     (state == S_LATCH),
        .word     (phase == PH_PC ? i_pc : phase == PH_REG ? i_reg : i_mem),
        .tx_ready (i_tx_ready),
        .tx_data  (ser_data),
        .tx_valid (ser_valid),
        .last     (ser_last)
    );
endmodule

// File: tb/tb_debug_dump_tx.sv
// tb_debug_dump_tx: frame-level checks of debug_dump_tx against a byte-queue reference model
module tb_debug_dump_tx;
    logic        i_clock = 0, i_reset = 0, i_dump_start = 0, i_tx_ready = 0;
    logic [31:0] i_pc = 0, i_reg = 0, i_mem = 0;
    logic [4:0]  o_reg_addr, o_mem_addr;
    logic        o_reg_send, o_mem_send, o_tx_valid, o_busy, o_done;
    logic [7:0]  o_tx_data;

    debug_dump_tx dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_dump_start(i_dump_start), .i_pc(i_pc),
        .o_reg_addr(o_reg_addr), .i_reg(i_reg), .o_mem_addr(o_mem_addr), .i_mem(i_mem),
        .o_reg_send(o_reg_send), .o_mem_send(o_mem_send), .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clock = ~i_clock;

    logic [31:0] rf [32];
    logic [31:0] mm [32];
    always @(posedge i_clock) begin
        i_reg <= o_reg_send ? rf[o_reg_addr] : $urandom;
        i_mem <= o_mem_send ? mm[o_mem_addr] : $urandom;
    end

    int n_checks = 0, n_fail = 0;
    int cyc = 0, done_cnt, rsend_cnt, msend_cnt, busy_cyc;
    logic [7:0] got[$], exp_q[$];
    bit stalled;
    logic [7:0] stall_byte;

    typedef struct {
        int          mode;
        bit          second;
        bit          rand_data;
        int          exp_bytes;
        int          exp_done;
        int          exp_rsend;
        int          exp_msend;
        int          exp_busy;
        logic [39:0] exp_head;
        logic [31:0] exp_tail;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_data(input bit rnd);
        i_pc = rnd ? $urandom : 32'h40;
        for (int k = 0; k < 32; k++) begin
            rf[k] = rnd ? $urandom : k;
            mm[k] = rnd ? $urandom : 32'hF000_0000 + k;
        end
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int w = 0; w < 65; w++) begin
            logic [31:0] v;
            v = w == 0 ? i_pc : w <= 32 ? rf[w-1] : mm[w-33];
            for (int b = 3; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
        end
    endtask

    task automatic step(input int mode);
        @(negedge i_clock);
        cyc++;
        i_tx_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0) : 1'($urandom_range(0, 1));
        if (stalled) begin
            check("hold_valid", o_tx_valid, 1);
            check("hold_data", o_tx_data, stall_byte);
        end
        if (o_done) done_cnt++;
        if (o_reg_send) rsend_cnt++;
        if (o_mem_send) msend_cnt++;
        if (o_busy) busy_cyc++;
        if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
        stalled = o_tx_valid && !i_tx_ready;
        stall_byte = o_tx_data;
    endtask

    task automatic clear_stats();
        got.delete();
        done_cnt = 0; rsend_cnt = 0; msend_cnt = 0; busy_cyc = 0;
        stalled = 0;
    endtask

    task automatic run_dump(input int mode, input bit second);
        bit fired = 0;
        clear_stats();
        i_dump_start = 1;
        step(mode);
        i_dump_start = 0;
        for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
            if (second && !fired && rsend_cnt == 5) begin
                i_dump_start = 1;
                fired = 1;
            end
            step(mode);
            i_dump_start = 0;
        end
        repeat (10) step(mode);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_nbytes"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check({tag, "_byte"}, {i[31:0], got[i]}, {i[31:0], exp_q[i]});
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 261, 1, 32, 32, 392, 40'hA5_0000_0040, 32'hF000_001F};
        vecs[1] = '{1, 0, 0, 261, 1, 32, 32, 0,   40'hA5_0000_0040, 32'hF000_001F};
        vecs[2] = '{0, 1, 0, 261, 1, 32, 32, 392, 40'hA5_0000_0040, 32'hF000_001F};
        vecs[3] = '{2, 0, 1, 261, 1, 32, 32, 0,   40'h0, 32'h0};
        vecs[4] = '{0, 0, 1, 261, 1, 32, 32, 392, 40'h0, 32'h0};

        repeat (2) @(negedge i_clock);
        check("rst_valid", o_tx_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_sends", {o_reg_send, o_mem_send}, 0);
        check("rst_data", o_tx_data, 0);
        check("rst_addrs", {o_reg_addr, o_mem_addr}, 0);
        i_reset = 1;
        @(negedge i_clock);

        for (int v = 0; v < 5; v++) begin
            logic [39:0] h;
            logic [31:0] t;
            load_data(vecs[v].rand_data);
            run_dump(vecs[v].mode, vecs[v].second);
            check_stream($sformatf("v%0d", v));
            check($sformatf("v%0d_done", v), done_cnt, vecs[v].exp_done);
            check($sformatf("v%0d_count", v), got.size(), vecs[v].exp_bytes);
            check($sformatf("v%0d_regsend", v), rsend_cnt, vecs[v].exp_rsend);
            check($sformatf("v%0d_memsend", v), msend_cnt, vecs[v].exp_msend);
            check($sformatf("v%0d_idle_busy", v), o_busy, 0);
            if (vecs[v].exp_busy != 0) check($sformatf("v%0d_busy_cycles", v), busy_cyc, vecs[v].exp_busy);
            if (!vecs[v].rand_data) begin
                h = '0;
                t = '0;
                for (int i = 0; i < 5 && i < got.size(); i++) h = {h[31:0], got[i]};
                for (int i = got.size() - 4; i >= 0 && i < got.size(); i++) t = {t[23:0], got[i]};
                check($sformatf("v%0d_head", v), h, vecs[v].exp_head);
                check($sformatf("v%0d_tail", v), t, vecs[v].exp_tail);
            end
        end

        // abort mid-frame after byte 100, then restart
        load_data(0);
        clear_stats();
        i_dump_start = 1;
        step(0);
        i_dump_start = 0;
        for (int c = 0; c < 2000 && got.size() < 100; c++) step(0);
        check("abort_reached100", got.size(), 100);
        @(negedge i_clock);
        i_reset = 0;
        @(negedge i_clock);
        check("abort_valid", o_tx_valid, 0);
        check("abort_busy", o_busy, 0);
        i_reset = 1;
        stalled = 0;
        repeat (20) step(0);
        check("abort_no_more_bytes", got.size(), 100);
        check("abort_no_done", done_cnt, 0);
        run_dump(0, 0);
        check("restart_first", got.size() > 0 ? got[0] : 8'h00, 8'hA5);
        check_stream("restart");
        check("restart_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_dump_tx.md
DEBUG_DUMP_TX -- requirements
Module: debug_dump_tx

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 32, datapath word width.
- NREGS, 32, register-file words dumped.
- MEM_WORDS, 32, data-memory words dumped.
- HEADER, 8'hA5, frame start byte.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clock, in, 1, single clock.
- i_reset, in, 1, synchronous active-low reset.
- i_dump_start, in, 1, one-cycle request to start a dump (halt detected).
- i_pc, in, DATA_WIDTH, current PC value.
- o_reg_addr, out, 5, register-file read index.
- i_reg, in, DATA_WIDTH, register read data, valid 1 cycle after o_reg_addr.
- o_mem_addr, out, clog2(MEM_WORDS), data-memory word index.
- i_mem, in, DATA_WIDTH, memory read data, valid 1 cycle after o_mem_addr.
- o_reg_send, out, 1, register-file debug read enable.
- o_mem_send, out, 1, memory debug read enable.
- o_tx_data, out, 8, byte toward the UART transmitter.
- o_tx_valid, out, 1, o_tx_data valid.
- i_tx_ready, in, 1, UART transmitter can accept a byte.
- o_busy, out, 1, dump in progress.
- o_done, out, 1, one-cycle pulse at dump end.

Function
REQ-003 The block SHALL be the transmit-side dumper of the MIPS debug protocol: it serialises PC, registers and memory into UART bytes. The loader side receives bytes and builds instruction words.
REQ-004 Frame SHALL be: HEADER; PC; reg[0..NREGS-1]; mem[0..MEM_WORDS-1]. Each word is sent as 4 bytes, MSB first. Defaults give 261 bytes.
REQ-005 FSM states SHALL be IDLE, HEADER, FETCH, LATCH, SEND, DONE.
REQ-006 IDLE->HEADER SHALL occur on i_dump_start=1; in all other states i_dump_start SHALL be ignored.
REQ-007 HEADER SHALL drive o_tx_data=HEADER with o_tx_valid=1 and go to FETCH on the handshake.
REQ-008 FETCH SHALL drive o_reg_addr or o_mem_addr for the current word with the matching send enable high for one cycle, then go to LATCH.
REQ-009 LATCH SHALL capture the word into a 32-bit shift register, set byte count to 0 and go to SEND.
- PC words SHALL skip the read cycle and be captured directly from i_pc.
REQ-010 A byte SHALL transfer only in a cycle where o_tx_valid=1 and i_tx_ready=1.
REQ-011 o_tx_data SHALL stay stable and o_tx_valid SHALL stay high until that transfer.
REQ-012 After the 4th byte of a word, SEND SHALL advance the word index and go to FETCH. Index order: PC -> reg 0 -> reg NREGS-1 -> mem 0 -> mem MEM_WORDS-1.
REQ-013 After the last memory byte the FSM SHALL enter DONE, pulse o_done for 1 cycle and return to IDLE.
REQ-014 o_busy SHALL be 1 in every state except IDLE.
REQ-015 With i_tx_ready held high, throughput SHALL be one byte per cycle within a word, plus 2 cycles of overhead per word (FETCH, LATCH).
REQ-016 Index counters SHALL not wrap: the register index stops at NREGS-1 and the memory index at MEM_WORDS-1.

Reset
REQ-017 When i_reset=0 at a clock edge, the block SHALL enter IDLE.
- o_tx_valid, o_busy, o_done, o_reg_send, o_mem_send SHALL be 0.
- o_tx_data, o_reg_addr, o_mem_addr and all counters SHALL be 0.
REQ-018 Reset asserted mid-dump SHALL abort the frame with no further bytes. The next i_dump_start after reset SHALL restart the frame at HEADER.

Structure
REQ-019 A shared package SHALL hold:
- the FSM state encoding;
- the HEADER constant;
- the word-index phase encoding (PC/REG/MEM).
REQ-020 One sub-module SHALL exist: word_serializer (32-bit load, 4-byte MSB-first shift, valid/ready output).

Verification
REQ-021 Reset, then i_dump_start with i_tx_ready=1, i_pc=32'h00000040, reg[k]=k, mem[k]=32'hF0000000+k:
- 261 bytes SHALL appear: A5, 00 00 00 40, 00 00 00 00, ...
- the final bytes SHALL be F0 00 00 1F;
- o_done SHALL pulse once.
REQ-022 i_tx_ready toggling 1 cycle high / 3 cycles low:
- every byte SHALL be held stable while stalled;
- the byte sequence SHALL equal that of REQ-021.
REQ-023 Second i_dump_start pulse during the register phase:
- SHALL be ignored, with byte count 261 and exactly one o_done.
REQ-024 i_reset=0 for 1 cycle after byte 100:
- o_tx_valid SHALL be 0 in the next cycle;
- a new i_dump_start SHALL emit A5 first.
REQ-025 Read-enable check: o_reg_send SHALL pulse 32 times, o_mem_send SHALL pulse 32 times, and each pulse SHALL be followed by a capture of the addressed word.
